// File: rtl/bist_memory.sv
// Single-port synchronous RAM with registered read and a March C- self-test.
// Bit 0 of word inj_addr reads back as 0 while inj_en is high.
module bist_memory #(
    parameter int a_width = 4,
    parameter int width   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [width-1:0]   data_in,
    input  logic [a_width-1:0] address,
    input  logic               write,
    input  logic               read,
    output logic [width-1:0]   data_out,
    output logic               rd_valid,
    output logic               collision,
    input  logic               bist_start,
    output logic               bist_busy,
    output logic               bist_done,
    output logic               bist_fail,
    output logic [a_width-1:0] fail_addr,
    input  logic               inj_en,
    input  logic [a_width-1:0] inj_addr
);

    localparam int D = 1 << a_width;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_CHK} state_t;

    state_t             state, state_n;
    logic [2:0]         elem;
    logic [a_width-1:0] baddr;
    logic [width-1:0]   bist_q;
    logic [width-1:0]   mem [D];

    logic               idle, desc, last, mismatch;
    logic               bist_we, addr_step;
    logic               we;
    logic [a_width-1:0] ra, wa;
    logic [width-1:0]   rd_word, wd, bg_wr, bg_rd;

    assign idle      = (state == S_IDLE);
    assign bist_busy = !idle;
    assign desc      = (elem == 3'd3) || (elem == 3'd4);
    assign last      = desc ? (baddr == '0) : (baddr == '1);

    // M0/M2/M4 write zeros, M1/M3 write ones; M2/M4 expect ones
    assign bg_wr    = (elem == 3'd1 || elem == 3'd3) ? '1 : '0;
    assign bg_rd    = (elem == 3'd2 || elem == 3'd4) ? '1 : '0;
    assign mismatch = (state == S_CHK) && (bist_q != bg_rd);

    assign ra = idle ? address : baddr;
    assign wa = ra;
    assign we = idle ? (write && !read) : bist_we;
    assign wd = idle ? data_in : bg_wr;

    always_comb begin
        rd_word = mem[ra];
        if (inj_en && ra == inj_addr)
            rd_word[0] = 1'b0;
    end

    always_comb begin
        state_n   = state;
        bist_we   = 1'b0;
        addr_step = 1'b0;
        unique case (state)
            S_IDLE: if (bist_start) state_n = S_WR;
            S_WR: begin
                bist_we   = 1'b1;
                addr_step = 1'b1;
                if (last) state_n = S_RD;
            end
            S_RD: state_n = S_CHK;
            S_CHK: begin
                bist_we   = (elem != 3'd5);
                addr_step = 1'b1;
                state_n   = (last && elem == 3'd5) ? S_IDLE : S_RD;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            collision <= 1'b0;
            bist_q    <= '0;
        end else begin
            rd_valid  <= idle && read && !write;
            collision <= idle && read && write;
            if (idle && read && !write)
                data_out <= rd_word;
            if (state == S_RD)
                bist_q <= rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem      <= '0;
            baddr     <= '0;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
        end else if (idle) begin
            if (bist_start) begin
                elem      <= '0;
                baddr     <= '0;
                bist_done <= 1'b0;
                bist_fail <= 1'b0;
                fail_addr <= '0;
            end
        end else begin
            if (mismatch) begin
                bist_fail <= 1'b1;
                if (!bist_fail) fail_addr <= baddr;
            end
            if (addr_step) begin
                if (last) begin
                    elem <= elem + 3'd1;
                    // M2->M3 starts at top, M4->M5 at bottom: hold
                    if (elem == 3'd3)
                        baddr <= baddr - 1'b1;
                    else if (elem != 3'd2 && elem != 3'd4)
                        baddr <= baddr + 1'b1;
                    if (elem == 3'd5) bist_done <= 1'b1;
                end else begin
                    baddr <= desc ? baddr - 1'b1 : baddr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bist_memory.sv
// Directed bench for bist_memory: normal access, collision, BIST pass/fail,
// mid-run reset and ignored bus inputs while busy.
module tb_bist_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic [3:0] address;
    logic       write;
    logic       read;
    logic [3:0] data_out;
    logic       rd_valid;
    logic       collision;
    logic       bist_start;
    logic       bist_busy;
    logic       bist_done;
    logic       bist_fail;
    logic [3:0] fail_addr;
    logic       inj_en;
    logic [3:0] inj_addr;

    int tests = 0;
    int fails = 0;
    int n;
    int busy_cnt;
    int bad;

    always #5 clk = ~clk;

    bist_memory #(.a_width(4), .width(4)) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .address(address),
        .write(write), .read(read),
        .data_out(data_out), .rd_valid(rd_valid),
        .collision(collision), .bist_start(bist_start),
        .bist_busy(bist_busy), .bist_done(bist_done),
        .bist_fail(bist_fail), .fail_addr(fail_addr),
        .inj_en(inj_en), .inj_addr(inj_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        address = a;
        data_in = d;
        write   = 1'b1;
        @(posedge clk); #1;
        write   = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a,
                           input logic [3:0] exp);
        address = a;
        read    = 1'b1;
        @(posedge clk); #1;
        read    = 1'b0;
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_data"}, data_out, exp);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, rd_valid, 0);
    endtask

    task automatic run_bist(input logic noise, output int edges,
                            output int busy_n, output int bad_n);
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        edges  = 0;
        busy_n = 0;
        bad_n  = 0;
        while (!bist_done && edges < 400) begin
            if (bist_busy) busy_n++;
            if (noise) begin
                write      = (edges % 2 == 0);
                read       = (edges % 2 == 1);
                bist_start = 1'b1;
                address    = 4'd2;
                data_in    = 4'hF;
            end
            @(posedge clk); #1;
            edges++;
            if (!bist_done && (rd_valid || collision)) bad_n++;
        end
        write      = 1'b0;
        read       = 1'b0;
        bist_start = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        data_in    = '0;
        address    = '0;
        write      = 1'b0;
        read       = 1'b1;
        bist_start = 1'b0;
        inj_en     = 1'b0;
        inj_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", bist_busy, 0);
        chk("rst_done", bist_done, 0);
        chk("rst_fail", bist_fail, 0);
        chk("rst_fail_addr", fail_addr, 0);
        read = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;

        do_write(4'd3, 4'hA);
        do_read("rd3", 4'd3, 4'hA);

        do_write(4'd5, 4'h6);
        address = 4'd5;
        data_in = 4'h9;
        read    = 1'b1;
        write   = 1'b1;
        @(posedge clk); #1;
        read    = 1'b0;
        write   = 1'b0;
        chk("coll_pulse", collision, 1);
        chk("coll_no_valid", rd_valid, 0);
        chk("coll_hold", data_out, 4'hA);
        @(posedge clk); #1;
        chk("coll_drop", collision, 0);
        do_read("rd5", 4'd5, 4'h6);

        run_bist(1'b0, n, busy_cnt, bad);
        chk("pass_done_edge", n, 176);
        chk("pass_busy_cycles", busy_cnt, 176);
        chk("pass_done", bist_done, 1);
        chk("pass_busy_off", bist_busy, 0);
        chk("pass_fail", bist_fail, 0);
        do_read("clr0", 4'd0, 4'h0);
        do_read("clr5", 4'd5, 4'h0);
        do_read("clr15", 4'd15, 4'h0);

        inj_en   = 1'b1;
        inj_addr = 4'd9;
        run_bist(1'b0, n, busy_cnt, bad);
        chk("inj_done_edge", n, 176);
        chk("inj_done", bist_done, 1);
        chk("inj_fail", bist_fail, 1);
        chk("inj_fail_addr", fail_addr, 9);
        repeat (3) @(posedge clk);
        #1;
        chk("inj_sticky", {bist_done, bist_fail}, 2'b11);
        inj_en = 1'b0;

        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        chk("restart_clear", {bist_busy, bist_done, bist_fail}, 3'b100);
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", bist_busy, 0);
        chk("abort_flags", {bist_done, bist_fail, fail_addr}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        do_write(4'd7, 4'h5);
        do_read("post_rst", 4'd7, 4'h5);
        run_bist(1'b0, n, busy_cnt, bad);
        chk("rerun_done_edge", n, 176);
        chk("rerun_pass", {bist_done, bist_fail}, 2'b10);

        run_bist(1'b1, n, busy_cnt, bad);
        chk("noise_done_edge", n, 176);
        chk("noise_pulses", bad, 0);
        chk("noise_pass", {bist_done, bist_fail}, 2'b10);
        @(posedge clk); #1;
        chk("noise_no_restart", bist_busy, 0);
        do_read("noise_rd2", 4'd2, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
